// File: rtl/mem_stage.sv
// MIPS memory-access stage: holds the EX payload, waits for the data-SRAM load
// response, aligns/extends it, and hands the result to WB. Define MS_FWD_EN to drive ms_fwd_bus.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    output logic        ms_allowin,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [37:0] ms_fwd_bus
);

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_type_e;

    logic        ms_valid;
    logic [73:0] ms_bus_r;
    logic        rbuf_valid;
    logic [31:0] rbuf_data;

    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {ld_type, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_r;

    logic        resp_pending;
    logic        ms_ready_go;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign resp_pending   = ms_valid && res_from_mem && !rbuf_valid;
    assign ms_ready_go    = !res_from_mem || rbuf_valid || (data_sram_data_ok && resp_pending);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    // Gated by reset so WB and ID see nothing even before the first reset edge.
    assign ms_to_ws_valid = !reset && ms_valid && ms_ready_go;

    assign ld_word = rbuf_valid ? rbuf_data : data_sram_rdata;
    assign ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ld_byte   = ld_word[7:0];
        load_data = ld_word;
        case (alu_result[1:0])
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        case (ld_type_e'(ld_type))
            LD_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   load_data = {24'd0, ld_byte};
            LD_H:    load_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   load_data = {16'd0, ld_half};
            default: load_data = ld_word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            rbuf_valid <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            // The buffer belongs to the resident entry; it empties whenever that entry leaves.
            if (ms_allowin) begin
                rbuf_valid <= 1'b0;
            end else if (data_sram_data_ok && resp_pending) begin
                rbuf_valid <= 1'b1;
            end
        end
    end

    // NOTE: payload and buffer data carry no reset; they are qualified by ms_valid/rbuf_valid.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus_r <= es_to_ms_bus;
        end
        if (!ms_allowin && data_sram_data_ok && resp_pending) begin
            rbuf_data <= data_sram_rdata;
        end
    end

`ifdef MS_FWD_EN
    assign ms_fwd_bus = reset ? 38'd0
                              : {ms_valid && gr_we && (!res_from_mem || ms_ready_go), dest, final_result};
`else
    assign ms_fwd_bus = 38'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases, then randomized traffic
// checked every cycle against a transaction-level model plus an in-order PC scoreboard.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_fwd_bus;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [73:0] mk(input logic [2:0] lt, input logic rfm, input logic we,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic [31:0] pcv);
        return {lt, rfm, we, dst, alu, pcv};
    endfunction

    // Load alignment computed with shifts and masks from the load rules.
    function automatic logic [31:0] load_value(input logic [2:0] lt, input int a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Model: the one payload the stage holds, and the response word if one has been captured.
    logic        m_valid = 1'b0;
    logic [73:0] m_bus   = '0;
    logic        m_have  = 1'b0;
    logic [31:0] m_word  = '0;
    logic [31:0] pc_q[$];

    function automatic logic m_is_load();
        return m_bus[70];
    endfunction

    function automatic logic m_ready();
        return !m_is_load() || m_have || data_sram_data_ok;
    endfunction

    function automatic logic m_allowin();
        return !m_valid || (m_ready() && ws_allowin);
    endfunction

    function automatic logic [31:0] m_result();
        logic [31:0] w;
        w = m_have ? m_word : data_sram_rdata;
        return m_is_load() ? load_value(m_bus[73:71], int'(m_bus[33:32]), w) : m_bus[63:32];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b0;
            m_have  = 1'b0;
            pc_q.delete();
        end else if (m_allowin()) begin
            if (es_to_ms_valid) begin
                m_bus = es_to_ms_bus;
                pc_q.push_back(es_to_ms_bus[31:0]);
            end
            m_valid = es_to_ms_valid;
            m_have  = 1'b0;
        end else if (m_valid && m_is_load() && !m_have && data_sram_data_ok) begin
            m_have = 1'b1;
            m_word = data_sram_rdata;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic exp_valid;
        logic [31:0] exp_pc;
        if (reset) begin
            check("reset_out_valid", 74'(ms_to_ws_valid), 74'd0);
            check("reset_fwd", 74'(ms_fwd_bus), 74'd0);
        end else begin
            exp_valid = m_valid && m_ready();
            check("allowin", 74'(ms_allowin), 74'(m_allowin()));
            check("out_valid", 74'(ms_to_ws_valid), 74'(exp_valid));
            if (exp_valid)
                check("out_bus", 74'(ms_to_ws_bus),
                      74'({m_bus[69], m_bus[68:64], m_result(), m_bus[31:0]}));
`ifdef MS_FWD_EN
            if (m_valid)
                check("fwd_bus", 74'(ms_fwd_bus),
                      74'({m_bus[69] && m_ready(), m_bus[68:64], m_result()}));
            else
                check("fwd_valid", 74'(ms_fwd_bus[37]), 74'd0);
`else
            check("fwd_tied", 74'(ms_fwd_bus), 74'd0);
`endif
            if (ms_to_ws_valid && ws_allowin) begin
                if (pc_q.size() == 0) begin
                    check("wb_unexpected", 74'(ms_to_ws_bus[31:0]), 74'h3_dead_dead);
                end else begin
                    exp_pc = pc_q.pop_front();
                    check("wb_order_pc", 74'(ms_to_ws_bus[31:0]), 74'(exp_pc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
    endtask

    // Enter one load, wait 'gap' cycles, then return rdata and check the WB result.
    task automatic directed_load(input string name, input logic [2:0] lt, input logic [31:0] alu,
                                 input logic [31:0] pcv, input int gap,
                                 input logic [31:0] rd, input logic [31:0] exp);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(lt, 1'b1, 1'b1, 5'd9, alu, pcv);
        ws_allowin     = 1'b1;
        step();
        idle();
        for (int i = 1; i < gap; i++) begin
            #1 check({name, "_wait_valid"}, 74'(ms_to_ws_valid), 74'd0);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1 check({name, "_valid"}, 74'(ms_to_ws_valid), 74'd1);
        check({name, "_result"}, 74'(ms_to_ws_bus[63:32]), 74'(exp));
        step();
        idle();
        #1 check({name, "_gone"}, 74'(ms_to_ws_valid), 74'd0);
    endtask

    initial begin
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        step();
        step();
        check("lit_reset_valid", 74'(ms_to_ws_valid), 74'd0);
        check("lit_reset_fwd", 74'(ms_fwd_bus), 74'd0);
        reset = 1'b0;

        // ALU op, no stall
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'b000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0010);
        #1 check("lit_alu_allowin", 74'(ms_allowin), 74'd1);
        step();
        idle();
        #1 check("lit_alu_valid", 74'(ms_to_ws_valid), 74'd1);
        check("lit_alu_bus", 74'(ms_to_ws_bus), 74'({1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0010}));
`ifdef MS_FWD_EN
        check("lit_alu_fwd", 74'(ms_fwd_bus), 74'({1'b1, 5'd5, 32'h1234_5678}));
`endif
        step();

        directed_load("lit_lb",  3'b001, 32'h0000_1003, 32'h0000_0100, 2, 32'h80FF_0011, 32'hFFFF_FF80);
        directed_load("lit_lhu", 3'b100, 32'h0000_2002, 32'h0000_0104, 1, 32'hBEEF_1234, 32'h0000_BEEF);
        directed_load("lit_lbu", 3'b010, 32'h0000_2001, 32'h0000_0108, 1, 32'hBEEF_1234, 32'h0000_0012);

        // WB stall during response: the word must come from the buffer.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'b000, 1'b1, 1'b1, 5'd3, 32'h0000_4000, 32'h0000_0200);
        step();
        idle();
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1 check("lit_stall_allowin", 74'(ms_allowin), 74'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1 check("lit_stall_hold_allowin", 74'(ms_allowin), 74'd0);
            step();
        end
        ws_allowin = 1'b1;
        #1 check("lit_stall_result", 74'(ms_to_ws_bus[63:32]), 74'h0_CAFE_F00D);
        step();
        #1 check("lit_stall_once", 74'(ms_to_ws_valid), 74'd0);

        // Back-to-back: LW leaves as an ALU op enters; a spurious data_ok follows.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'b000, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0000_0300);
        step();
        es_to_ms_bus      = mk(3'b000, 1'b0, 1'b1, 5'd6, 32'h0000_ABCD, 32'h0000_0304);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        #1 check("lit_b2b_allowin", 74'(ms_allowin), 74'd1);
        check("lit_b2b_lw", 74'(ms_to_ws_bus[63:32]), 74'h0_1111_2222);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h3333_3333;
        #1 check("lit_b2b_alu", 74'(ms_to_ws_bus), 74'({1'b1, 5'd6, 32'h0000_ABCD, 32'h0000_0304}));
        step();
        idle();

        // Reset mid-WAIT, then a late data_ok.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'b000, 1'b1, 1'b1, 5'd7, 32'h0000_6000, 32'h0000_0400);
        step();
        idle();
`ifdef MS_FWD_EN
        #1 check("lit_wait_fwd_valid", 74'(ms_fwd_bus[37]), 74'd0);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        #1 check("lit_rst_late_ok", 74'(ms_to_ws_valid), 74'd0);
        step();
        data_sram_data_ok = 1'b0;
        #1 check("lit_rst_after", 74'(ms_to_ws_valid), 74'd0);

        // Randomized traffic; data_ok mostly only while a load awaits its response.
        for (int i = 0; i < 4000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            es_to_ms_valid = ($urandom_range(0, 99) < 60);
            es_to_ms_bus   = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 5'($urandom),
                                $urandom, 32'h1000_0000 + 32'(i) * 4);
            ws_allowin      = ($urandom_range(0, 99) < 70);
            data_sram_rdata = $urandom;
            if (m_valid && m_is_load() && !m_have)
                data_sram_data_ok = ($urandom_range(0, 99) < 35);
            else
                data_sram_data_ok = ($urandom_range(0, 99) < 5);
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
